instr_issue_queue: RTL
======================

# instr_issue_queue

Buffered, parametrised instruction decode stage for the matrix coprocessor. Accepts 32-bit instruction words over a valid/ready handshake and holds them in a small FIFO. Decodes the head entry into opcode, linear element address and 16-bit data, and presents the result in a registered output stage with its own valid/ready handshake. It sits between the host-facing instruction port and the execution FSM, and replaces purely combinational decode with back-pressure, configurable matrix geometry and bounds checking.

## Interface
- DIM, 5: matrix dimension (rows = cols); 2..8.
- NUM_MAT, 4: number of addressable matrices; 1..4.
- DEPTH, 4: FIFO depth; power of two, ≥2.
- ADDR_W, 7: element address width; must be ≥ clog2(NUM_MAT*DIM*DIM).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO and output stage.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO can accept.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded instruction held.
- out_ready  in  1  consumer takes it.
- out_opcode  out  4  decoded opcode.
- out_addr  out  ADDR_W  linear element address.
- out_data  out  16  data field.
- out_err  out  1  location out of range.
- level  out  clog2(DEPTH)+1  FIFO occupancy (excludes output stage).

## Operation
- Fields: opcode = instr[3:0]; col = instr[6:4]; row = instr[9:7]; id = instr[11:10].
- Data: opcode[3]=1 → instr[19:4]; opcode[3]=0 → instr[27:12].
- Location form (opcode[3]=0): addr = id*DIM*DIM + row*DIM + col, computed at ADDR_W, truncated modulo 2^ADDR_W.
- Immediate form (opcode[3]=1): addr = 0, err = 0; location bits are ignored.
- Push when in_valid & in_ready. in_ready = !full & !flush. It has no combinational dependency on out_ready, so no push happens when full, even during a pop.
- Output stage states: EMPTY (out_valid=0) and HOLD (out_valid=1).
  - EMPTY → HOLD when FIFO non-empty: pop the head, decode it, register the result.
  - HOLD & out_ready: if FIFO non-empty, reload from the head and stay in HOLD; else go to EMPTY.
  - HOLD & !out_ready: all out_* held stable.
- Total capacity is DEPTH + 1. Pointers wrap modulo DEPTH.
- flush: FIFO empties, level = 0, output stage goes to EMPTY. A push in the same cycle is dropped. Flush beats a simultaneous pop.
- Reset (any time, including mid-transfer): out_valid=0, out_opcode=0, out_addr=0, out_data=0, out_err=0, level=0, pointers=0. in_ready goes high on the first edge after release.

## Timing
- Accept at edge k into an empty block → out_valid high after edge k+1 (1-cycle latency).
- Back-to-back: one instruction per cycle sustained while out_ready=1.
- level updates on the same edge as the push/pop. A simultaneous push and pop leaves level unchanged.
- in_ready is registered-state only: a function of level and flush.

## Configuration
- ISSUE_BOUNDS_CHECK_EN defined: for the location form, row ≥ DIM, col ≥ DIM or id ≥ NUM_MAT → out_err=1 and out_addr=0. The instruction still issues; opcode and data pass through unchanged.
- Not defined: no range check, out_err tied 0, address is the truncated formula result.

## Structure
- Package issue_pkg: field bit positions and widths, INSTR_W=32, DATA_W=16, and a packed decoded-instruction struct (opcode, addr, data, err).
- Sub-module issue_fifo: parametrised synchronous FIFO with push/pop, full/empty and level. Decode and the output stage live in the top.

## Test plan
- Reset with defaults; push 0x0ABCD532 → one cycle later out_opcode=0x2, out_addr=38, out_data=0xABCD, out_err=0.
- Push 0x00012349 → out_opcode=0x9, out_data=0x1234, out_addr=0, out_err=0.
- Push 0x00000282 (row=5) → with macro: out_err=1, out_addr=0. Without macro: out_err=0, out_addr=25.
- Hold out_ready=0 and push 6 words → 5 accepted, in_ready low after the 5th, level=4, outputs stable. Release out_ready → words emerge in order, one per cycle.
- Fill to level=3, assert flush together with in_valid → next cycle level=0, out_valid=0, pushed word not seen.
- Assert rst_n low mid-stream with out_valid=1 → all outputs 0 immediately, without waiting for a clock edge. After release, a push round-trips correctly.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared field layout and decoded-instruction type for the instruction issue queue.
// The address field is sized for the widest supported ADDR_W; the top keeps only the low ADDR_W bits.
package issue_pkg;
  localparam int INSTR_W      = 32;
  localparam int DATA_W       = 16;
  localparam int OPC_LSB      = 0;
  localparam int OPC_W        = 4;
  localparam int COL_LSB      = 4;
  localparam int ROW_LSB      = 7;
  localparam int RC_W         = 3;
  localparam int ID_LSB       = 10;
  localparam int ID_W         = 2;
  localparam int IMM_DATA_LSB = 4;
  localparam int LOC_DATA_LSB = 12;
  localparam int ADDR_MAX_W   = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_t;

  typedef struct packed {
    logic [OPC_W-1:0]      opcode;
    logic [ADDR_MAX_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic                  err;
  } issue_t;
endpackage

// File: rtl/issue_fifo.sv
// Small synchronous FIFO with combinational head read, occupancy level and synchronous flush.
// Flush takes priority over push and pop.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             push_en;
  logic             pop_en;

  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign rdata   = mem_reg[rd_ptr_reg];
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;

  // Storage needs no reset: nothing is read until the level says it is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_reg[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_en, pop_en})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end
endmodule

// File: rtl/instr_issue_queue.sv
// Buffered instruction decode: FIFO, head decode and a registered output stage with handshake.
// Define ISSUE_BOUNDS_CHECK_EN to flag out-of-range row/col/id on location-form instructions.
module instr_issue_queue
  import issue_pkg::*;
#(
  parameter int DIM     = 5,
  parameter int NUM_MAT = 4,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPC_W-1:0]           out_opcode,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     level
);
  out_state_t         state_reg;
  issue_t             out_reg;
  logic               ready_en_reg;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic [INSTR_W-1:0] head;
  logic               unused_bits;

  function automatic issue_t decode(input logic [INSTR_W-1:0] w);
    issue_t            d;
    logic [RC_W-1:0]   row;
    logic [RC_W-1:0]   col;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] a;
    d   = '0;
    col = w[COL_LSB +: RC_W];
    row = w[ROW_LSB +: RC_W];
    id  = w[ID_LSB +: ID_W];
    a   = ADDR_W'(id) * ADDR_W'(DIM * DIM) + ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
    d.opcode = w[OPC_LSB +: OPC_W];
    if (d.opcode[OPC_W-1]) begin
      d.data = w[IMM_DATA_LSB +: DATA_W];
    end else begin
      d.data = w[LOC_DATA_LSB +: DATA_W];
`ifdef ISSUE_BOUNDS_CHECK_EN
      if (32'(row) >= DIM || 32'(col) >= DIM || 32'(id) >= NUM_MAT) d.err = 1'b1;
      else d.addr = ADDR_MAX_W'(a);
`else
      d.addr = ADDR_MAX_W'(a);
`endif
    end
    return d;
  endfunction

`ifndef ISSUE_BOUNDS_CHECK_EN
  localparam int unused_num_mat = NUM_MAT;
`endif

  // ready_en_reg keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_en_reg && !fifo_full && !flush;
  assign pop      = !flush && !fifo_empty && (state_reg == ST_EMPTY || out_ready);

  issue_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata (in_instr),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      out_reg      <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (flush) begin
        state_reg <= ST_EMPTY;
      end else if (pop) begin
        state_reg <= ST_HOLD;
        out_reg   <= decode(head);
      end else if (state_reg == ST_HOLD && out_ready) begin
        state_reg <= ST_EMPTY;
      end
    end
  end

  assign out_valid  = (state_reg == ST_HOLD);
  assign out_opcode = out_reg.opcode;
  assign out_addr   = out_reg.addr[ADDR_W-1:0];
  assign out_data   = out_reg.data;
  assign out_err    = out_reg.err;

  assign unused_bits = ^{head[INSTR_W-1:28], out_reg.addr};
endmodule
